// File: rtl/rx_ctrl_pkg.sv
// Shared types and constants for the receiver retune control path.
package rx_ctrl_pkg;

    typedef enum logic [0:0] {
        StRun,
        StSettle
    } state_e;

    localparam logic [7:0]  RATE_48K = 8'd0;
    localparam logic [7:0]  RATE_96K = 8'd1;

    localparam logic [31:0] DEF_RESET_FREQ    = 32'd7074000;
    localparam logic [3:0]  DEF_FREQ_SETTLE   = 4'd2;
    localparam logic [3:0]  DEF_RATE_SETTLE   = 4'd8;
    localparam logic [7:0]  DEF_MAX_RATE_CODE = RATE_96K;

    typedef struct packed {
        logic [31:0] freq;
        logic [7:0]  rate;
    } cfg_t;

    // A settle length of zero still discards one sample.
    function automatic logic [3:0] settle_len(input logic [3:0] n);
        return (n == 4'd0) ? 4'd1 : n;
    endfunction

endpackage

// File: rtl/rx_retune_sequencer.sv
// Applies host tuning/rate requests on sample boundaries and discards the
// samples corrupted while the DDC decimation chain settles.
module rx_retune_sequencer
    import rx_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_FREQ    = DEF_RESET_FREQ,
    parameter logic [3:0]  FREQ_SETTLE   = DEF_FREQ_SETTLE,
    parameter logic [3:0]  RATE_SETTLE   = DEF_RATE_SETTLE,
    parameter logic [7:0]  MAX_RATE_CODE = DEF_MAX_RATE_CODE
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_valid,
    input  logic [31:0]        cfg_freq,
    input  logic [7:0]         cfg_rate,
    output logic               cfg_ready,
    output logic               cfg_err,
    output logic [31:0]        rx_freq,
    output logic [7:0]         rx_rate,
    input  logic               sample_strobe,
    input  logic signed [23:0] in_real,
    input  logic signed [23:0] in_imag,
    output logic               out_valid,
    output logic signed [23:0] out_real,
    output logic signed [23:0] out_imag,
    output logic               settling,
    output logic [15:0]        drop_count
);

    state_e             r_state;
    logic [3:0]         r_count;
    logic               r_slot_full;
    cfg_t               r_slot;
    logic [31:0]        r_rx_freq;
    logic [7:0]         r_rx_rate;
    logic               r_out_valid;
    logic signed [23:0] r_out_real;
    logic signed [23:0] r_out_imag;
    logic               r_cfg_err;
    logic [15:0]        r_drop_count;

    state_e             w_state_d;
    logic [3:0]         w_count_d;
    logic               w_slot_full_d;
    cfg_t               w_slot_d;
    logic [31:0]        w_rx_freq_d;
    logic [7:0]         w_rx_rate_d;
    logic               w_out_valid_d;
    logic signed [23:0] w_out_real_d;
    logic signed [23:0] w_out_imag_d;
    logic               w_cfg_err_d;
    logic               w_drop;
    logic               w_settle_done;
    logic [3:0]         w_count_dec;

    assign w_settle_done = (r_count <= 4'd1);
    assign w_count_dec   = w_settle_done ? 4'd0 : 4'(r_count - 4'd1);

    always_comb begin
        w_state_d     = r_state;
        w_count_d     = r_count;
        w_slot_full_d = r_slot_full;
        w_slot_d      = r_slot;
        w_rx_freq_d   = r_rx_freq;
        w_rx_rate_d   = r_rx_rate;
        w_out_valid_d = 1'b0;
        w_out_real_d  = r_out_real;
        w_out_imag_d  = r_out_imag;
        w_cfg_err_d   = 1'b0;
        w_drop        = 1'b0;

        if (cfg_valid && !r_slot_full) begin
            if (cfg_rate <= MAX_RATE_CODE) begin
                w_slot_d      = '{freq: cfg_freq, rate: cfg_rate};
                w_slot_full_d = 1'b1;
            end else begin
                w_cfg_err_d = 1'b1;
            end
        end

        if (sample_strobe) begin
            if (r_slot_full) begin
                // Apply: the sample straddling the retune is always lost.
                w_drop        = 1'b1;
                w_rx_freq_d   = r_slot.freq;
                w_rx_rate_d   = r_slot.rate;
                w_slot_full_d = 1'b0;
                if (r_slot.rate != r_rx_rate) begin
                    w_count_d = settle_len(RATE_SETTLE);
                    w_state_d = StSettle;
                end else if (r_slot.freq != r_rx_freq) begin
                    w_count_d = settle_len(FREQ_SETTLE);
                    w_state_d = StSettle;
                end else if (r_state == StSettle) begin
                    w_count_d = w_count_dec;
                    if (w_settle_done) w_state_d = StRun;
                end
            end else if (r_state == StRun) begin
                w_out_valid_d = 1'b1;
                w_out_real_d  = in_real;
                w_out_imag_d  = in_imag;
            end else begin
                w_drop    = 1'b1;
                w_count_d = w_count_dec;
                if (w_settle_done) w_state_d = StRun;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= StSettle;
            r_count      <= settle_len(RATE_SETTLE);
            r_slot_full  <= 1'b0;
            r_slot       <= '0;
            r_rx_freq    <= RESET_FREQ;
            r_rx_rate    <= RATE_48K;
            r_out_valid  <= 1'b0;
            r_out_real   <= '0;
            r_out_imag   <= '0;
            r_cfg_err    <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_state     <= w_state_d;
            r_count     <= w_count_d;
            r_slot_full <= w_slot_full_d;
            r_slot      <= w_slot_d;
            r_rx_freq   <= w_rx_freq_d;
            r_rx_rate   <= w_rx_rate_d;
            r_out_valid <= w_out_valid_d;
            r_out_real  <= w_out_real_d;
            r_out_imag  <= w_out_imag_d;
            r_cfg_err   <= w_cfg_err_d;
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign cfg_ready  = !r_slot_full;
    assign cfg_err    = r_cfg_err;
    assign rx_freq    = r_rx_freq;
    assign rx_rate    = r_rx_rate;
    assign out_valid  = r_out_valid;
    assign out_real   = r_out_real;
    assign out_imag   = r_out_imag;
    assign settling   = (r_state == StSettle);
    assign drop_count = r_drop_count;

endmodule
